ram_fifo_ctrl: RTL and testbench

- Valid/ready FIFO controller that drives an external 2^ADDR_W x DATA_W synchronous RAM of the team's standard form (ports w_en/w_addr/w_data, r_en/r_addr/r_data).
- Sits directly upstream of the RAM. It converts a producer stream into RAM writes, and RAM reads into a consumer stream.
- Contains a 2-entry output buffer that hides the RAM's 1-cycle read latency, so the block sustains 1 word/cycle.

---
 rtl/ram_fifo_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ram_fifo_ctrl
//   Valid/ready FIFO controller in front of an external 2**ADDR_W x DATA_W
//   synchronous RAM. Producer words are written straight into the RAM. RAM
//   reads refill a 2-entry output buffer. The buffer hides the RAM's 1-cycle
//   read latency, so the FIFO streams 1 word/cycle.
//
//   Parameters
//     DATA_W     word width of the stream and of the RAM
//     ADDR_W     RAM address width, DEPTH = 2**ADDR_W
//
//   Ports
//     clk, rst_n                 clock and asynchronous active-low reset
//     in_valid/in_ready/in_data  producer stream
//     out_valid/out_ready/out_data  consumer stream (head of FIFO)
//     ram_w_en/ram_w_addr/ram_w_data  RAM write port
//     ram_r_en/ram_r_addr             RAM read request
//     ram_r_data                      RAM read data, valid 1 cycle after r_en
//     level, overflow                 only with FIFO_STATUS_EN defined:
//                                     occupancy and a sticky dropped-push flag
//
//   Optional build macro: FIFO_STATUS_EN
// ---------------------------------------------------------------------------
module ram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [DATA_W-1:0] ram_w_data,
  output logic              ram_r_en,
  output logic [ADDR_W-1:0] ram_r_addr,
`ifdef FIFO_STATUS_EN
  output logic [ADDR_W:0]   level,
  output logic              overflow,
`endif
  input  logic [DATA_W-1:0] ram_r_data
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W:0]    DEPTH_V  = (CNT_W + 1)'(DEPTH);

  // Registered state
  logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]  mem_cnt_q,  mem_cnt_d;
  logic              pend_q,     pend_d;
  logic [1:0]        obuf_cnt_q, obuf_cnt_d;
  logic [DATA_W-1:0] buf0_q,     buf0_d;
  logic [DATA_W-1:0] buf1_q,     buf1_d;
  // Low while in reset and for the first cycle after release; keeps the
  // producer interface closed and the RAM write data quiet during reset.
  logic              alive_q;

  // Combinational decode
  logic [CNT_W:0]    total_s;
  logic              in_ready_s;
  logic              push_s;
  logic              pop_s;
  logic [2:0]        after_pop_s;
  logic              fetch_s;
  logic [1:0]        slot_s;

  // Occupancy and handshake decode from registered counts
  always_comb begin
    total_s     = {1'b0, mem_cnt_q}
                + {{CNT_W{1'b0}}, pend_q}
                + {{(CNT_W - 1){1'b0}}, obuf_cnt_q};
    // A same-cycle pop never frees space: readiness depends on state only.
    in_ready_s  = alive_q & (total_s < DEPTH_V);
    push_s      = in_valid & in_ready_s;
    pop_s       = (obuf_cnt_q != 2'd0) & out_ready;
    // Buffer words plus the in-flight read, once this cycle's pop leaves.
    after_pop_s = {1'b0, obuf_cnt_q} + {2'b00, pend_q} - {2'b00, pop_s};
    fetch_s     = (mem_cnt_q != CNT_ZERO) & (after_pop_s < 3'd2);
    // Landing slot is the first free entry after the pop shifts the buffer.
    slot_s      = obuf_cnt_q - {1'b0, pop_s};
  end

  // Pointer and counter next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_cnt_d  = mem_cnt_q;
    pend_d     = fetch_s;
    obuf_cnt_d = obuf_cnt_q + {1'b0, pend_q} - {1'b0, pop_s};

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (fetch_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, fetch_s})
      2'b10:   mem_cnt_d = mem_cnt_q + CNT_ONE;
      2'b01:   mem_cnt_d = mem_cnt_q - CNT_ONE;
      default: mem_cnt_d = mem_cnt_q;
    endcase
  end

  // Output buffer: pop shifts entry 1 down, then landing RAM data fills a slot
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;

    if (pop_s) begin
      buf0_d = buf1_q;
      buf1_d = {DATA_W{1'b0}};
    end else begin
      buf0_d = buf0_q;
      buf1_d = buf1_q;
    end

    if (pend_q) begin
      case (slot_s)
        2'd0:    buf0_d = ram_r_data;
        2'd1:    buf1_d = ram_r_data;
        default: buf1_d = buf1_d;
      endcase
    end else begin
      buf0_d = buf0_d;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= {ADDR_W{1'b0}};
      rd_ptr_q   <= {ADDR_W{1'b0}};
      mem_cnt_q  <= CNT_ZERO;
      pend_q     <= 1'b0;
      obuf_cnt_q <= 2'd0;
      buf0_q     <= {DATA_W{1'b0}};
      buf1_q     <= {DATA_W{1'b0}};
      alive_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      pend_q     <= pend_d;
      obuf_cnt_q <= obuf_cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      alive_q    <= 1'b1;
    end
  end

`ifdef FIFO_STATUS_EN
  logic [CNT_W-1:0] level_q,    level_d;
  logic             overflow_q, overflow_d;

  // Status next-state: level tracks total, overflow latches any refused word
  always_comb begin
    level_d    = total_s[CNT_W-1:0]
               + {{(CNT_W - 1){1'b0}}, push_s}
               - {{(CNT_W - 1){1'b0}}, pop_s};
    overflow_d = overflow_q | (alive_q & in_valid & ~in_ready_s);
  end

  // Status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q    <= CNT_ZERO;
      overflow_q <= 1'b0;
    end else begin
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  assign level    = level_q;
  assign overflow = overflow_q;
`endif

  // Stream and RAM port drive
  assign in_ready   = in_ready_s;
  assign out_valid  = (obuf_cnt_q != 2'd0);
  assign out_data   = buf0_q;
  assign ram_w_en   = push_s;
  assign ram_w_addr = wr_ptr_q;
  assign ram_w_data = alive_q ? in_data : {DATA_W{1'b0}};
  assign ram_r_en   = fetch_s;
  assign ram_r_addr = rd_ptr_q;

  ram_fifo_ctrl_chk #(
    .ADDR_W (ADDR_W)
  ) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .total      (total_s),
    .obuf_cnt   (obuf_cnt_q),
    .mem_cnt    (mem_cnt_q),
    .fetch      (fetch_s),
    .ram_w_en   (push_s),
    .ram_w_addr (wr_ptr_q),
    .ram_r_addr (rd_ptr_q)
  );

endmodule

// ---------------------------------------------------------------------------
// ram_fifo_ctrl_chk
//   Invariant checker for ram_fifo_ctrl: occupancy bound, buffer bound,
//   no fetch from an empty RAM, and no same-address read/write.
//   Ports mirror the internal counts and RAM port signals of the controller.
// ---------------------------------------------------------------------------
module ram_fifo_ctrl_chk #(
  parameter int ADDR_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  input logic [ADDR_W+1:0] total,
  input logic [1:0]        obuf_cnt,
  input logic [ADDR_W:0]   mem_cnt,
  input logic              fetch,
  input logic              ram_w_en,
  input logic [ADDR_W-1:0] ram_w_addr,
  input logic [ADDR_W-1:0] ram_r_addr
);
  localparam logic [ADDR_W+1:0] DEPTH_V = (ADDR_W + 2)'(2 ** ADDR_W);

  a_total_bound: assert property (@(posedge clk) disable iff (!rst_n)
    total <= DEPTH_V);

  a_obuf_bound: assert property (@(posedge clk) disable iff (!rst_n)
    obuf_cnt <= 2'd2);

  a_fetch_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
    fetch |-> (mem_cnt != {(ADDR_W + 1){1'b0}}));

  a_no_rdw: assert property (@(posedge clk) disable iff (!rst_n)
    (ram_w_en && fetch) |-> (ram_w_addr != ram_r_addr));
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
module tb_ram_fifo_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              ram_w_en;
  logic [ADDR_W-1:0] ram_w_addr;
  logic [DATA_W-1:0] ram_w_data;
  logic              ram_r_en;
  logic [ADDR_W-1:0] ram_r_addr;
  logic [DATA_W-1:0] ram_r_data = 8'h00;
`ifdef FIFO_STATUS_EN
  logic [ADDR_W:0]   level;
  logic              overflow;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int first_pop;
  int last_pop;
  int npop;
  int exp_wptr;
  logic [DATA_W-1:0] sb[$];
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .ram_w_en   (ram_w_en),
    .ram_w_addr (ram_w_addr),
    .ram_w_data (ram_w_data),
    .ram_r_en   (ram_r_en),
    .ram_r_addr (ram_r_addr),
`ifdef FIFO_STATUS_EN
    .level      (level),
    .overflow   (overflow),
`endif
    .ram_r_data (ram_r_data)
  );

  // external synchronous RAM model
  always @(posedge clk) begin
    if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
    if (ram_r_en) ram_r_data <= mem[ram_r_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: compare every word the consumer takes
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("pop_with_empty_sb", {31'b0, out_valid}, 32'd0);
      end else begin
        logic [DATA_W-1:0] e;
        e = sb.pop_front();
        check("out_data", {24'b0, out_data}, {24'b0, e});
      end
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      npop++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    first_pop = -1;
    last_pop  = -1;
    npop      = 0;
  endtask

  // present a word for one cycle; acc is whether the FIFO must take it
  task automatic push_word(input logic [DATA_W-1:0] d, input logic acc);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    check("in_ready", {31'b0, in_ready}, {31'b0, acc});
    check("ram_w_en", {31'b0, ram_w_en}, {31'b0, acc});
    if (acc) begin
      check("ram_w_addr", {28'b0, ram_w_addr}, exp_wptr[31:0]);
      check("ram_w_data", {24'b0, ram_w_data}, {24'b0, d});
      sb.push_back(d);
      exp_wptr = (exp_wptr + 1) % DEPTH;
    end
    step();
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && out_valid === 1'b0) break;
    end
    check("drain_sb_empty", sb.size(), 32'd0);
    check("drain_out_valid", {31'b0, out_valid}, 32'd0);
    step();
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    check("rst_out_valid",  {31'b0, out_valid}, 32'd0);
    check("rst_out_data",   {24'b0, out_data}, 32'd0);
    check("rst_in_ready",   {31'b0, in_ready}, 32'd0);
    check("rst_w_en",       {31'b0, ram_w_en}, 32'd0);
    check("rst_w_addr",     {28'b0, ram_w_addr}, 32'd0);
    check("rst_w_data",     {24'b0, ram_w_data}, 32'd0);
    check("rst_r_en",       {31'b0, ram_r_en}, 32'd0);
    check("rst_r_addr",     {28'b0, ram_r_addr}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h33;
    out_ready = 1'b0;
    exp_wptr  = 0;
    clear_stats();

    // reset and idle
    check_reset_outputs();
    step();
    rst_n = 1'b1;
    repeat (5) step();
    @(negedge clk);
    check("idle_out_valid", {31'b0, out_valid}, 32'd0);
    check("idle_in_ready",  {31'b0, in_ready}, 32'd1);
    check("idle_w_en",      {31'b0, ram_w_en}, 32'd0);
    check("idle_r_en",      {31'b0, ram_r_en}, 32'd0);
`ifdef FIFO_STATUS_EN
    check("idle_level",    {27'b0, level}, 32'd0);
    check("idle_overflow", {31'b0, overflow}, 32'd0);
`endif
    step();

    // single word latency
    push_word(8'h11, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_r_en",      {31'b0, ram_r_en}, 32'd1);
    check("lat_r_addr",    {28'b0, ram_r_addr}, 32'd0);
    check("lat_valid_n1",  {31'b0, out_valid}, 32'd0);
    step();
    @(negedge clk);
    check("lat_valid_n2",  {31'b0, out_valid}, 32'd0);
    check("lat_r_en_off",  {31'b0, ram_r_en}, 32'd0);
    step();
    @(negedge clk);
    check("lat_valid",     {31'b0, out_valid}, 32'd1);
    check("lat_data",      {24'b0, out_data}, 32'h11);
    step();
    repeat (3) step();
    @(negedge clk);
    check("hold_valid",    {31'b0, out_valid}, 32'd1);
    check("hold_data",     {24'b0, out_data}, 32'h11);
`ifdef FIFO_STATUS_EN
    check("hold_level",    {27'b0, level}, 32'd1);
`endif
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    check("after_pop_valid", {31'b0, out_valid}, 32'd0);
    check("single_npop", npop, 32'd1);
    step();

    // fill to full, 17th word refused
    clear_stats();
    for (int i = 0; i < DEPTH; i++) push_word(8'(i), 1'b1);
    push_word(8'hAA, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("full_in_ready",  {31'b0, in_ready}, 32'd0);
    check("full_out_valid", {31'b0, out_valid}, 32'd1);
    check("full_out_data",  {24'b0, out_data}, 32'h00);
`ifdef FIFO_STATUS_EN
    check("full_level",    {27'b0, level}, 32'd16);
    check("full_overflow", {31'b0, overflow}, 32'd1);
`endif
    step();

    // drain in order, no gaps
    out_ready = 1'b1;
    wait_drain(40);
    out_ready = 1'b0;
    check("drain_npop",    npop, 32'd16);
    check("drain_gapless", last_pop - first_pop + 1, npop);

    // continuous streaming across 4 pointer wraps
    rst_n = 1'b0;
    sb.delete();
    step();
    rst_n = 1'b1;
    exp_wptr = 0;
    step();
    step();
    clear_stats();
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) push_word(8'(i), 1'b1);
    in_valid = 1'b0;
    wait_drain(20);
    out_ready = 1'b0;
    check("stream_npop",    npop, 32'd64);
    check("stream_gapless", last_pop - first_pop + 1, npop);

    // reset in mid-stream discards contents
    clear_stats();
    for (int i = 0; i < 5; i++) push_word(8'h80 + 8'(i), 1'b1);
    in_data = 8'h77;
    rst_n = 1'b0;
    sb.delete();
    check_reset_outputs();
    step();
    in_valid = 1'b0;
    rst_n = 1'b1;
    exp_wptr = 0;
    step();
    step();
    @(negedge clk);
    check("mrst_in_ready",  {31'b0, in_ready}, 32'd1);
    check("mrst_out_valid", {31'b0, out_valid}, 32'd0);
`ifdef FIFO_STATUS_EN
    check("mrst_level",    {27'b0, level}, 32'd0);
    check("mrst_overflow", {31'b0, overflow}, 32'd0);
`endif
    step();
    push_word(8'h5A, 1'b1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain(10);
    out_ready = 1'b0;
    check("mrst_npop", npop, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
